// File: rtl/pe_au_pkg.sv
// Shared widths, OPMODE field layout and operand-select codes for the PE arithmetic unit.
package pe_au_pkg;

    localparam int unsigned A_W   = 27;
    localparam int unsigned B_W   = 18;
    localparam int unsigned P_W   = 48;
    localparam int unsigned M_W   = A_W + B_W;
    localparam int unsigned SHIFT = 17;

    localparam int unsigned OP_W     = 9;
    localparam int unsigned OP_X_LSB = 0;
    localparam int unsigned OP_X_W   = 2;
    localparam int unsigned OP_Y_LSB = 2;
    localparam int unsigned OP_Y_W   = 2;
    localparam int unsigned OP_Z_LSB = 4;
    localparam int unsigned OP_Z_W   = 3;
    localparam int unsigned OP_W_LSB = 7;
    localparam int unsigned OP_W_W   = 2;

    localparam logic [P_W-1:0] P_ONES = {P_W{1'b1}};

    typedef enum logic [1:0] {
        X_ZERO = 2'b00,
        X_M    = 2'b01,
        X_P    = 2'b10,
        X_AB   = 2'b11
    } x_sel_e;

    // Y_MPART is the partial-product companion of X_M; M is counted once via X.
    typedef enum logic [1:0] {
        Y_ZERO  = 2'b00,
        Y_MPART = 2'b01,
        Y_ONES  = 2'b10,
        Y_C     = 2'b11
    } y_sel_e;

    typedef enum logic [2:0] {
        Z_ZERO     = 3'b000,
        Z_PCIN     = 3'b001,
        Z_P        = 3'b010,
        Z_C        = 3'b011,
        Z_RSV4     = 3'b100,
        Z_PCIN_SHR = 3'b101,
        Z_P_SHR    = 3'b110,
        Z_RSV7     = 3'b111
    } z_sel_e;

    typedef enum logic [1:0] {
        W_ZERO = 2'b00,
        W_P    = 2'b01,
        W_RSV  = 2'b10,
        W_C    = 2'b11
    } w_sel_e;

    // Arithmetic right shift used for cascade accumulation across PEs.
    function automatic logic [P_W-1:0] cascade_shr(input logic [P_W-1:0] v);
        return P_W'($signed(v) >>> SHIFT);
    endfunction

endpackage

// File: rtl/pe_au_pipe_reg.sv
// Optional single pipeline stage with enable and synchronous active-low reset; STAGES=0 is a wire.
module pe_au_pipe_reg #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (STAGES == 0) begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst_n, en};
            assign q = d;
        end else begin : g_reg
            // Stage register: reset wins over enable.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (en) begin
                    q <= d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/pe_au.sv
// PE arithmetic unit: signed 27x18 multiply feeding a four-operand 48-bit adder into the P register.
module pe_au
    import pe_au_pkg::*;
#(
    parameter int unsigned ABREG = 1,
    parameter int unsigned MREG  = 1,
    parameter int unsigned CREG  = 1
) (
    input  logic            clock_i,
    input  logic            reset_n_i,
    input  logic            CREG_en_i,
    input  logic [OP_W-1:0] OPMODE_i,
    input  logic [A_W-1:0]  A_i,
    input  logic [B_W-1:0]  B_i,
    input  logic [P_W-1:0]  C_i,
    input  logic [P_W-1:0]  PCIN_i,
    output logic [P_W-1:0]  P_o,
    output logic [P_W-1:0]  PCOUT_o
);

    logic [A_W-1:0]        a_q;
    logic [B_W-1:0]        b_q;
    logic signed [M_W-1:0] a_ext;
    logic signed [M_W-1:0] b_ext;
    logic signed [M_W-1:0] prod;
    logic [P_W-1:0]        m_d;
    logic [P_W-1:0]        m_q;
    logic [P_W-1:0]        c_q;
    logic [P_W-1:0]        ab_cat;
    logic [P_W-1:0]        p_q;
    logic [P_W-1:0]        p_next;
    logic [P_W-1:0]        x_op;
    logic [P_W-1:0]        y_op;
    logic [P_W-1:0]        z_op;
    logic [P_W-1:0]        w_op;
    x_sel_e                x_sel;
    y_sel_e                y_sel;
    z_sel_e                z_sel;
    w_sel_e                w_sel;

    pe_au_pipe_reg #(.WIDTH(A_W), .STAGES(ABREG)) u_a_reg (
        .clk   (clock_i),
        .rst_n (reset_n_i),
        .en    (1'b1),
        .d     (A_i),
        .q     (a_q)
    );

    pe_au_pipe_reg #(.WIDTH(B_W), .STAGES(ABREG)) u_b_reg (
        .clk   (clock_i),
        .rst_n (reset_n_i),
        .en    (1'b1),
        .d     (B_i),
        .q     (b_q)
    );

    // Operands widened to the full product width so the signed product cannot truncate.
    assign a_ext = M_W'($signed(a_q));
    assign b_ext = M_W'($signed(b_q));
    assign prod  = a_ext * b_ext;
    assign m_d   = {{(P_W - M_W){prod[M_W-1]}}, prod};

    pe_au_pipe_reg #(.WIDTH(P_W), .STAGES(MREG)) u_m_reg (
        .clk   (clock_i),
        .rst_n (reset_n_i),
        .en    (1'b1),
        .d     (m_d),
        .q     (m_q)
    );

    pe_au_pipe_reg #(.WIDTH(P_W), .STAGES(CREG)) u_c_reg (
        .clk   (clock_i),
        .rst_n (reset_n_i),
        .en    (CREG_en_i),
        .d     (C_i),
        .q     (c_q)
    );

    assign ab_cat = {{(P_W - M_W){1'b0}}, a_q, b_q};

    assign x_sel = x_sel_e'(OPMODE_i[OP_X_LSB +: OP_X_W]);
    assign y_sel = y_sel_e'(OPMODE_i[OP_Y_LSB +: OP_Y_W]);
    assign z_sel = z_sel_e'(OPMODE_i[OP_Z_LSB +: OP_Z_W]);
    assign w_sel = w_sel_e'(OPMODE_i[OP_W_LSB +: OP_W_W]);

    // X/Y/Z/W operand selection.
    always_comb begin
        x_op = '0;
        y_op = '0;
        z_op = '0;
        w_op = '0;

        case (x_sel)
            X_M:     x_op = m_q;
            X_P:     x_op = p_q;
            X_AB:    x_op = ab_cat;
            default: x_op = '0;
        endcase

        case (y_sel)
            Y_ONES:  y_op = P_ONES;
            Y_C:     y_op = c_q;
            default: y_op = '0;
        endcase

        case (z_sel)
            Z_PCIN:     z_op = PCIN_i;
            Z_P:        z_op = p_q;
            Z_C:        z_op = c_q;
            Z_PCIN_SHR: z_op = cascade_shr(PCIN_i);
            Z_P_SHR:    z_op = cascade_shr(p_q);
            default:    z_op = '0;
        endcase

        case (w_sel)
            W_P:     w_op = p_q;
            W_C:     w_op = c_q;
            default: w_op = '0;
        endcase
    end

    // Four-operand sum, wrapping modulo 2^48.
    assign p_next = x_op + y_op + z_op + w_op;

    // Result register; loads every cycle.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            p_q <= '0;
        end else begin
            p_q <= p_next;
        end
    end

    assign P_o     = p_q;
    assign PCOUT_o = p_q;

endmodule

// File: tb/tb_pe_au.sv
// Self-checking bench for pe_au at default and all-zero pipeline settings side by side.
module tb_pe_au;

    localparam int MAXC = 2048;

    logic        clock_i = 1'b0;
    logic        reset_n_i;
    logic        creg_en;
    logic [8:0]  opmode;
    logic [26:0] a;
    logic [17:0] b;
    logic [47:0] c;
    logic [47:0] pcin;
    logic [47:0] p_def, pc_def, p_zero, pc_zero;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Input history per clock edge, consumed by the reference model.
    logic [26:0] ha  [MAXC];
    logic [17:0] hb  [MAXC];
    logic [47:0] hc  [MAXC];
    logic [47:0] hpc [MAXC];
    logic [8:0]  hop [MAXC];
    logic        hr  [MAXC];
    logic [47:0] mp  [2];
    logic [47:0] mc  [2];

    always #5 clock_i = ~clock_i;

    pe_au #(.ABREG(1), .MREG(1), .CREG(1)) u_def (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .CREG_en_i (creg_en),
        .OPMODE_i  (opmode),
        .A_i       (a),
        .B_i       (b),
        .C_i       (c),
        .PCIN_i    (pcin),
        .P_o       (p_def),
        .PCOUT_o   (pc_def)
    );

    pe_au #(.ABREG(0), .MREG(0), .CREG(0)) u_zero (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .CREG_en_i (creg_en),
        .OPMODE_i  (opmode),
        .A_i       (a),
        .B_i       (b),
        .C_i       (c),
        .PCIN_i    (pcin),
        .P_o       (p_zero),
        .PCOUT_o   (pc_zero)
    );

    function automatic logic rst_seen(input int lo, input int hi);
        logic r = 1'b0;
        for (int k = lo; k <= hi; k++) if (hr[k]) r = 1'b1;
        return r;
    endfunction

    function automatic logic [47:0] asr17(input logic [47:0] v);
        longint s = longint'($signed(v));
        return 48'(s >>> 17);
    endfunction

    // Next P from the arithmetic definition, using operands as they were d edges ago.
    function automatic logic [47:0] mdl_next(input int dab, input int dmr, input int dc,
                                              input logic [47:0] p, input logic [47:0] creg_v);
        logic [47:0] m = '0, ab = '0, cv, x, y, z, w;
        longint la, lb;
        logic [8:0] op = hop[cyc];
        int dm = dab + dmr;
        if (hr[cyc]) return 48'd0;
        if (cyc - dm >= 0 && !rst_seen(cyc - dm, cyc - 1)) begin
            la = longint'($signed(ha[cyc - dm]));
            lb = longint'($signed(hb[cyc - dm]));
            m  = 48'(la * lb);
        end
        if (cyc - dab >= 0 && !rst_seen(cyc - dab, cyc - 1))
            ab = {21'd0, ha[cyc - dab], hb[cyc - dab]};
        cv = (dc != 0) ? creg_v : hc[cyc];
        case (op[1:0])
            2'b01:   x = m;
            2'b10:   x = p;
            2'b11:   x = ab;
            default: x = '0;
        endcase
        case (op[3:2])
            2'b10:   y = 48'hFFFF_FFFF_FFFF;
            2'b11:   y = cv;
            default: y = '0;
        endcase
        case (op[6:4])
            3'b001:  z = hpc[cyc];
            3'b010:  z = p;
            3'b011:  z = cv;
            3'b101:  z = asr17(hpc[cyc]);
            3'b110:  z = asr17(p);
            default: z = '0;
        endcase
        case (op[8:7])
            2'b01:   w = p;
            2'b11:   w = cv;
            default: w = '0;
        endcase
        return x + y + z + w;
    endfunction

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk2(input string nm, input logic [47:0] e_def, input logic [47:0] e_zero);
        chk({nm, "_def"}, p_def, e_def);
        chk({nm, "_def_pcout"}, pc_def, e_def);
        chk({nm, "_zero"}, p_zero, e_zero);
        chk({nm, "_zero_pcout"}, pc_zero, e_zero);
    endtask

    // One clock: log inputs, advance the model, clock the DUTs, compare against the model.
    task automatic tick();
        logic [47:0] n0, n1;
        ha[cyc] = a; hb[cyc] = b; hc[cyc] = c; hpc[cyc] = pcin; hop[cyc] = opmode;
        hr[cyc] = !reset_n_i;
        n0 = mdl_next(1, 1, 1, mp[0], mc[0]);
        n1 = mdl_next(0, 0, 0, mp[1], mc[1]);
        mp[0] = n0;
        mp[1] = n1;
        for (int i = 0; i < 2; i++) begin
            if (!reset_n_i)   mc[i] = '0;
            else if (creg_en) mc[i] = c;
        end
        @(posedge clock_i);
        #1;
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget cyc=%0d actual=%0d required<%0d", cyc, cyc, MAXC);
            $fatal(1);
        end
        chk("model_def", p_def, mp[0]);
        chk("model_zero", p_zero, mp[1]);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    typedef struct {
        logic [26:0] a;
        logic [17:0] b;
        logic [47:0] c;
        logic [47:0] pcin;
        logic [8:0]  op;
        logic [47:0] exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{27'd3,         18'd5, 48'd7,     48'd0,               9'b000110101, 48'd22};
        tbl[1]  = '{27'h7FF_FFFF,  18'd2, 48'd0,     48'd0,               9'b000110101, 48'hFFFF_FFFF_FFFE};
        tbl[2]  = '{27'd0,         18'd0, 48'd0,     48'h0000_0004_0000,  9'b001010000, 48'd2};
        tbl[3]  = '{27'd0,         18'd0, 48'd0,     48'h8000_0000_0000,  9'b001010000, 48'hFFFF_C000_0000};
        tbl[4]  = '{27'd1,         18'd1, 48'd0,     48'd0,               9'b000000011, 48'h0000_0004_0001};
        tbl[5]  = '{27'd0,         18'd0, 48'd0,     48'd0,               9'b000001000, 48'hFFFF_FFFF_FFFF};
        tbl[6]  = '{27'd6,         18'd7, 48'd0,     48'h1234,            9'b000000100, 48'd0};
        tbl[7]  = '{27'd6,         18'd7, 48'd0,     48'h1234,            9'b001000000, 48'd0};
        tbl[8]  = '{27'd6,         18'd7, 48'd0,     48'h1234,            9'b001110000, 48'd0};
        tbl[9]  = '{27'd0,         18'd0, 48'h123,   48'd0,               9'b110000000, 48'h123};
        tbl[10] = '{27'd0,         18'd0, 48'd5,     48'd0,               9'b000111100, 48'd10};
        tbl[11] = '{27'd0,         18'd0, 48'd0,     48'h1234,            9'b000010000, 48'h1234};

        reset_n_i = 1'b0; creg_en = 1'b1; opmode = '0;
        a = '0; b = '0; c = '0; pcin = '0;
        mp[0] = '0; mp[1] = '0; mc[0] = '0; mc[1] = '0;

        // Reset
        ticks(2);
        chk2("reset", 48'd0, 48'd0);
        reset_n_i = 1'b1;

        // Steady-state operand/selector vectors
        for (int i = 0; i < 12; i++) begin
            a = tbl[i].a; b = tbl[i].b; c = tbl[i].c; pcin = tbl[i].pcin;
            opmode = tbl[i].op; creg_en = 1'b1;
            ticks(4);
            chk2($sformatf("vec%0d", i), tbl[i].exp, tbl[i].exp);
        end

        // A/B latency: 3 edges at defaults, 1 edge with no pipeline
        a = '0; b = '0; c = '0; pcin = '0; opmode = 9'b000110101;
        ticks(4);
        a = 27'd3; b = 18'd5;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk2($sformatf("ab_lat%0d", k), (k >= 3) ? 48'd15 : 48'd0, 48'd15);
        end

        // Accumulation from P=0
        a = 27'd1; b = 18'd4; opmode = '0;
        ticks(3);
        chk2("acc_start", 48'd0, 48'd0);
        opmode = 9'b000100101;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk2($sformatf("acc%0d", k), 48'(4 * k), 48'(4 * k));
        end

        // C enable hold and release
        a = '0; b = '0; c = 48'd7; creg_en = 1'b1; opmode = 9'b000110000;
        ticks(4);
        chk2("c_load", 48'd7, 48'd7);
        c = 48'd9; creg_en = 1'b0;
        ticks(3);
        chk2("c_hold", 48'd7, 48'd9);
        creg_en = 1'b1;
        tick();
        chk2("c_en1", 48'd7, 48'd9);
        tick();
        chk2("c_en2", 48'd9, 48'd9);

        // Wrap-around of all-ones plus one
        a = 27'd1; b = 18'd1; c = '0; opmode = '0;
        ticks(3);
        opmode = 9'b000001000;
        tick();
        chk2("wrap_ones", 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF);
        opmode = 9'b010110101;
        tick();
        chk2("wrap_zero", 48'd0, 48'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset_n_i = ($urandom_range(0, 39) != 0);
            creg_en   = 1'($urandom);
            opmode    = 9'($urandom);
            a         = 27'($urandom);
            b         = 18'($urandom);
            c         = {16'($urandom), 32'($urandom)};
            pcin      = {16'($urandom), 32'($urandom)};
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pe_au.md
# pe_au

Processing-element arithmetic unit: a DSP-slice-style signed 27×18 multiply followed by a 48-bit four-input adder with opmode-selected operands and an output register. It is the MAC/accumulate primitive of the AMNS modular-multiplier processing elements. It chains to a neighbour through PCIN/PCOUT and supports 17-bit-shifted cascade accumulation.

## Interface
- ABREG, default 1: A/B input pipeline stages (0 or 1).
- MREG, default 1: multiplier output register stages (0 or 1).
- CREG, default 1: C input register stages (0 or 1).
- clock_i  in  1  single clock; all registers rise-edge.
- reset_n_i  in  1  synchronous, active-low reset.
- CREG_en_i  in  1  clock enable of the C register (ignored when CREG=0).
- OPMODE_i  in  9  operand select: W=[8:7], Z=[6:4], Y=[3:2], X=[1:0].
- A_i  in  27  signed multiplicand.
- B_i  in  18  signed multiplier.
- C_i  in  48  addend.
- PCIN_i  in  48  cascade input from the previous PE's PCOUT_o.
- P_o  out  48  registered result.
- PCOUT_o  out  48  cascade output, identical to P_o.

## Operation
- M = sign-extend-48(signed A × signed B), which is 45 significant bits.
- P_next = X + Y + Z + W, modulo 2^48. There is no carry-out and no overflow flag.
- X [1:0]:
  - 00 → 0
  - 01 → M
  - 10 → P
  - 11 → zero-extended {A,B}, which is 45 bits
- Y [3:2]:
  - 00 → 0
  - 01 → 0. This is the partial-product companion of X=01; M is counted once, through X. Y=01 with X≠01 also gives 0.
  - 10 → 48'hFFFF_FFFF_FFFF
  - 11 → C
- Z [6:4]:
  - 000 → 0
  - 001 → PCIN
  - 010 → P
  - 011 → C
  - 101 → PCIN >>> 17, arithmetic
  - 110 → P >>> 17, arithmetic
  - 100 and 111 → 0
- W [8:7]:
  - 00 → 0
  - 01 → P
  - 10 → 0
  - 11 → C
- P in the selectors is the current P register value, which gives accumulation.
- C in the selectors is the C-register output when CREG=1, otherwise C_i directly.
- A/B used by M and by {A,B} come from the A/B registers when ABREG=1, otherwise directly from A_i/B_i.
- OPMODE_i is not registered; it applies in the cycle in which P samples.
- Example: OPMODE 9'b000110101 gives X=M, Y=0, Z=C, W=0, so P = A·B + C.

## Timing
- Reset: when reset_n_i=0 at a clock edge, the A, B, M, C and P registers all load 0. P_o and PCOUT_o read 0 from the next cycle. Reset overrides CREG_en_i.
- The A/B/M/P registers load every cycle; they have no enable.
- The C register loads only when CREG_en_i=1 and otherwise holds its value.
- Latency, A/B to P_o: ABREG + MREG + 1 cycles. With all parameters at 0 it is one cycle; with defaults it is 3 cycles.
- Latency, C to P_o: CREG + 1 cycles.
- Latency, PCIN/OPMODE to P_o: 1 cycle.
- The pipeline is fully throughput-1; a new operand set may be applied every cycle.
- The unit has no handshake. Callers must align operands to the per-path latencies above.
- PCOUT_o is the P register itself; it adds no extra delay.

## Structure
- Package pe_au_pkg holds:
  - localparams for the OPMODE field positions;
  - enums for the X/Y/Z/W select codes;
  - the widths A_W=27, B_W=18, P_W=48;
  - the cascade shift SHIFT=17.
- One natural sub-module is pe_au_pipe_reg: a parameterised width/STAGES (0|1) register with enable and sync active-low reset.
  - It is instanced for A, B, M and C.
  - STAGES=0 is a wire.
- The multiplier, the muxes and the adder live in pe_au itself.

## Test plan
- Run all scenarios at the defaults (ABREG=MREG=CREG=1) and again at all-zero parameters, checking the latencies.
- Scenarios:
  - Reset and A·B. Hold reset_n_i=0 for 2 cycles → P_o=PCOUT_o=0. Release; apply A=3, B=5, C=7, OPMODE=9'b000110101 → P_o=22 after the A/B latency.
  - Signed multiply. A=27'h7FFFFFF (−1), B=2, C=0, same OPMODE → P_o=48'hFFFF_FFFF_FFFE.
  - Accumulation. OPMODE=9'b000100101 (Z=P), A=1, B=4 held for 4 cycles from P=0 → P_o steps 4, 8, 12, 16.
  - Cascade shift. PCIN=48'h0000_0004_0000, OPMODE=9'b001010000 (Z=PCIN>>>17) → P_o=2. Repeat with PCIN=48'h8000_0000_0000 → P_o=48'hFFFF_C000_0000.
  - C enable. Hold CREG_en_i=0 while C_i changes 7→9, with OPMODE=9'b000110000 (Z=C) → P_o stays 7. Set the enable to 1 → P_o=9 after CREG+1 cycles.
  - Wrap-around. P=48'hFFFF_FFFF_FFFF, add 1 via OPMODE=9'b010110101 with A=1, B=1, C=0 → P_o=0 with no error.
